multi_button_counter: RTL and testbench
=======================================

// Module: multi_button_counter
// PURPOSE
//  Debounced multi-button up/down counter that drives the seven_segment display
//  driver with NUM_DIGITS nibbles. It is the parametrised successor to the
//  single-button press counter.
//  Adds decrement, clear, run-time HEX/DEC mode toggle, hold-to-auto-repeat, and
//  wrap/overflow reporting. It sits between the board buttons and seven_segment.
// PARAMETERS
//  NUM_DIGITS       8     number of 4-bit digits in the count (1..8)
//  DEBOUNCE_CYCLES  16    cycles a synced input must differ from its stable level before it is accepted (>=2)
//  HOLD_CYCLES      0     cycles held before auto-repeat starts; 0 = auto-repeat disabled
//  REPEAT_CYCLES    8     auto-repeat pulse period once repeating (>=1)
//  RESET_MODE_DEC   0     mode after reset: 0 = HEX, 1 = DEC
// PORTS
//  clk          in   1             system clock
//  reset        in   1             synchronous, active-high reset
//  btn          in   4             raw async buttons: [0] INC, [1] DEC, [2] CLR, [3] MODE
//  encoded      out  NUM_DIGITS*4  count, digit i = encoded[4i+3:4i]
//  digit_point  out  NUM_DIGITS    active-low decimal points to seven_segment
//  dec_mode     out  1             1 = BCD counting, 0 = hex counting
//  wrap         out  1             1-cycle pulse when the count wraps (max->0 or 0->max)
// BEHAVIOUR
//  Reset (any cycle, including mid-debounce or mid-repeat): values after reset
//   - encoded = 0, wrap = 0, dec_mode = RESET_MODE_DEC
//   - all debounce/repeat state cleared; stable levels = 0
//   - digit_point = '1 except bit0 = ~dec_mode
//  Per button, two-flop synchroniser (ASYNC_REG), then debounce:
//   - synced == stable: debounce counter = 0
//   - else counter++; when it reaches DEBOUNCE_CYCLES-1 and still differs, the
//     stable level flips and the counter clears
//   - glitches shorter than DEBOUNCE_CYCLES are fully rejected
//  Press event: a 1-cycle pulse, registered, on the stable 0->1 transition.
//   Latency from btn steady high to the pulse = 2 + DEBOUNCE_CYCLES + 1 cycles.
//   Releases generate no event.
//  Auto-repeat (INC/DEC only, HOLD_CYCLES>0):
//   - hold counter starts at the press event
//   - after HOLD_CYCLES more cycles stable-high: extra pulse, then one every REPEAT_CYCLES
//   - stable low stops repeat and clears the counters
//  Count update is applied the cycle after the event pulse. Priority order:
//   - reset
//   - CLR: encoded = 0
//   - MODE: dec_mode toggles, encoded = 0
//   - INC and DEC events in the same cycle: no change
//   - INC alone: +1; DEC alone: -1
//  HEX: plain binary on NUM_DIGITS*4 bits; all-F + 1 = 0, 0 - 1 = all-F; wrap pulses.
//  DEC: BCD ripple per digit; 9+1 gives 0 and carries; 0-1 gives 9 and borrows.
//   All-9 + 1 = 0 and 0 - 1 = all-9; wrap pulses.
//  A digit > 9 never exists in DEC mode, because a mode change clears the count.
//  wrap is registered, coincident with the encoded update, and low otherwise.
//  btn changes during an active debounce window only restart that button's counter.
// STRUCTURE
//  counting_pkg:
//   - localparams BTN_INC=0, BTN_DEC=1, BTN_CLR=2, BTN_MODE=3, NUM_BTN=4
//   - function bcd_step(value, up) returning {wrap, next}, shared with tests
//  Sub-module button_debounce:
//   - sync + debounce + press pulse + optional auto-repeat
//   - params DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES
//   - instantiated NUM_BTN times via generate; CLR/MODE instances use HOLD_CYCLES=0
//  Top holds the count register, mode flag, wrap and digit_point logic.
//  Counter widths use $clog2(param+1).
// TESTING (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, NUM_DIGITS=2)
//  1 HEX INC: 3-cycle INC glitch -> no change; INC steady high -> encoded 0x01
//    exactly 8 cycles after the rise (7 to pulse, +1 to update); release -> no change.
//  2 HEX wrap: preload via 255 presses; 256th INC -> encoded 0x00, one wrap pulse.
//    At 0x00, DEC -> 0xFF, wrap pulse.
//  3 DEC mode: MODE press -> dec_mode=1, encoded 0x00, digit_point=2'b10.
//    DEC press -> 0x99 + wrap; INC x10 from 0x09 -> 0x19.
//  4 Auto-repeat: hold INC 60 cycles from 0 -> pulses at press, +20, +25, +30...
//    Final encoded checked against the model (0x08); release stops increments.
//  5 Priority: INC and DEC event pulses same cycle -> unchanged.
//    CLR with INC same cycle -> 0x00.
//  6 Reset while INC is mid-debounce and DEC is auto-repeating -> everything clears.
//    No event fires until btn is released and re-pressed.

Source files
------------

// File: rtl/counting_pkg.sv
// Shared button indices and the single-digit BCD step used by the counter
// (and by any test model that wants the same arithmetic).
package counting_pkg;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_CLR  = 2;
  localparam int BTN_MODE = 3;
  localparam int NUM_BTN  = 4;

  // Returns {carry_or_borrow, next_digit} for one BCD digit.
  function automatic logic [4:0] bcd_step(input logic [3:0] value, input logic up);
    if (up) return (value == 4'd9) ? {1'b1, 4'd0} : {1'b0, value + 4'd1};
    else    return (value == 4'd0) ? {1'b1, 4'd9} : {1'b0, value - 4'd1};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser, debounce, registered press pulse and
// optional hold-to-auto-repeat.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic sync1;
  (* ASYNC_REG = "TRUE" *) logic sync2;
  logic [CW-1:0] db_cnt;
  logic stable, stable_d, press, rpt, rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Any return to the stable level restarts the window, so short glitches never flip it.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt   <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= rise;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        stable <= ~stable;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_d;

  generate
    if (HOLD_CYCLES > 0) begin : g_repeat
      localparam int HW = $clog2(HOLD_CYCLES + 1);
      localparam int RW = $clog2(REPEAT_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
      localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);
      logic [HW-1:0] hold_cnt;
      logic [RW-1:0] rep_cnt;
      logic repeating;

      // hold_cnt equals the number of cycles since the press pulse.
      always_ff @(posedge clk) begin
        if (reset || !stable) begin
          hold_cnt  <= '0;
          rep_cnt   <= '0;
          repeating <= 1'b0;
          rpt       <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (rise) begin
            hold_cnt <= '0;
          end else if (!repeating) begin
            if (hold_cnt == HOLD_MAX) begin
              rpt       <= 1'b1;
              repeating <= 1'b1;
              rep_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end else if (rep_cnt == REP_MAX) begin
            rpt     <= 1'b1;
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end
    end else begin : g_no_repeat
      assign rpt = 1'b0;
    end
  endgenerate

  assign pulse = press | rpt;

endmodule

// File: rtl/multi_button_counter.sv
// Debounced INC/DEC/CLR/MODE counter feeding seven_segment, counting in hex or
// BCD with a one-cycle wrap pulse.
module multi_button_counter
  import counting_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 8,
  parameter bit RESET_MODE_DEC  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              btn,
  output logic [NUM_DIGITS*4-1:0] encoded,
  output logic [NUM_DIGITS-1:0]   digit_point,
  output logic                    dec_mode,
  output logic                    wrap
);

  localparam int W = NUM_DIGITS * 4;

  logic [NUM_BTN-1:0] ev;
  logic [W-1:0] hex_next, bcd_next;
  logic hex_wrap, cy, up;
  logic [4:0] st;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    ((b == BTN_INC || b == BTN_DEC) ? HOLD_CYCLES : 0),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[b]),
      .pulse(ev[b])
    );
  end

  // BCD ripple: each digit steps only while the previous one carried/borrowed.
  always_comb begin
    up       = ev[BTN_INC];
    hex_next = up ? encoded + 1'b1 : encoded - 1'b1;
    hex_wrap = up ? &encoded : ~|encoded;
    bcd_next = encoded;
    cy       = 1'b1;
    st       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      st = bcd_step(encoded[4*i +: 4], up);
      if (cy) begin
        bcd_next[4*i +: 4] = st[3:0];
        cy                 = st[4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      encoded  <= '0;
      dec_mode <= RESET_MODE_DEC;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ev[BTN_CLR]) begin
        encoded <= '0;
      end else if (ev[BTN_MODE]) begin
        dec_mode <= ~dec_mode;
        encoded  <= '0;
      end else if (ev[BTN_INC] ^ ev[BTN_DEC]) begin
        encoded <= dec_mode ? bcd_next : hex_next;
        wrap    <= dec_mode ? cy : hex_wrap;
      end
    end
  end

  always_comb begin
    digit_point    = '1;
    digit_point[0] = ~dec_mode;
  end

endmodule

// File: tb/tb_multi_button_counter.sv
// Directed bench: debounce timing, hex/BCD wrap, mode, auto-repeat, priority, reset.
module tb_multi_button_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [7:0] encoded;
  logic [1:0] digit_point;
  logic       dec_mode, wrap;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wrap_cnt = 0;
  int w0;

  multi_button_counter #(
    .NUM_DIGITS(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20),
    .REPEAT_CYCLES(5), .RESET_MODE_DEC(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .encoded(encoded),
    .digit_point(digit_point), .dec_mode(dec_mode), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap) wrap_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Short tap: released well before the 20-cycle hold threshold.
  task automatic press(input logic [3:0] m);
    @(negedge clk) btn = m;
    repeat (8) @(posedge clk);
    @(negedge clk) btn = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_encoded", encoded, 8'h00);
    check("rst_wrap", wrap, 1'b0);
    check("rst_dec_mode", dec_mode, 1'b0);
    check("rst_dp", digit_point, 2'b11);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: glitch rejection and exact press latency
    btn = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk) btn = '0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("glitch", encoded, 8'h00);
    btn = 4'b0001;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("lat7", encoded, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("lat8", encoded, 8'h01);
    btn = '0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("release", encoded, 8'h01);

    // 2: hex wrap both directions
    w0 = wrap_cnt;
    repeat (254) press(4'b0001);
    check("hex_ff", encoded, 8'hFF);
    check("hex_nowrap", wrap_cnt - w0, 0);
    press(4'b0001);
    check("hex_inc_wrap", encoded, 8'h00);
    check("hex_inc_wrapcnt", wrap_cnt - w0, 1);
    press(4'b0010);
    check("hex_dec_wrap", encoded, 8'hFF);
    check("hex_dec_wrapcnt", wrap_cnt - w0, 2);

    // 3: decimal mode
    press(4'b1000);
    check("mode_dec", dec_mode, 1'b1);
    check("mode_clear", encoded, 8'h00);
    check("mode_dp", digit_point, 2'b10);
    w0 = wrap_cnt;
    press(4'b0010);
    check("bcd_dec_wrap", encoded, 8'h99);
    check("bcd_dec_wrapcnt", wrap_cnt - w0, 1);
    press(4'b0001);
    check("bcd_inc_wrap", encoded, 8'h00);
    check("bcd_inc_wrapcnt", wrap_cnt - w0, 2);
    repeat (9) press(4'b0001);
    check("bcd_09", encoded, 8'h09);
    repeat (10) press(4'b0001);
    check("bcd_19", encoded, 8'h19);

    // 4: auto-repeat (pulses at edges 7, 27, 32, ..., 57 after the rise)
    press(4'b0100);
    check("clr", encoded, 8'h00);
    check("clr_keep_mode", dec_mode, 1'b1);
    btn = 4'b0001;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("rpt_first", encoded, 8'h01);
    repeat (19) @(posedge clk);
    @(negedge clk);
    check("rpt_before_hold", encoded, 8'h01);
    @(posedge clk);
    @(negedge clk);
    check("rpt_at_hold", encoded, 8'h02);
    repeat (25) @(posedge clk);
    @(negedge clk) btn = '0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rpt_final", encoded, 8'h08);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rpt_stopped", encoded, 8'h08);

    // 5: priority
    press(4'b0011);
    check("inc_dec_same", encoded, 8'h08);
    press(4'b0101);
    check("clr_over_inc", encoded, 8'h00);

    // 6: reset during DEC repeat and INC debounce
    btn = 4'b0010;
    repeat (33) @(posedge clk);
    @(negedge clk);
    check("pre_rst_val", encoded, 8'h97);
    btn = 4'b0011;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    btn   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_encoded", encoded, 8'h00);
    check("mid_rst_mode", dec_mode, 1'b0);
    check("mid_rst_dp", digit_point, 2'b11);
    check("mid_rst_wrap", wrap, 1'b0);
    reset = 1'b0;
    w0 = wrap_cnt;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", encoded, 8'h00);
    check("post_rst_nowrap", wrap_cnt - w0, 0);
    press(4'b0001);
    check("post_rst_press", encoded, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
